// File: rtl/prog_loader.sv
// Byte-stream program loader: receives a length-prefixed, XOR-checksummed
// stream of instruction bytes, writes them word by word into instruction
// memory, and releases the processor reset once the checksum matches.
module prog_loader #(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {StIdle, StLen, StData, StChk, StDone, StErr} state_e;

  localparam logic [15:0] LP_DEPTH = 16'(DEPTH_WORDS);

  state_e      r_state;
  state_e      w_state_next;
  logic [15:0] r_len;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_chk;
  logic [23:0] r_word;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_accept;
  logic [15:0] w_len_full;
  logic        w_last_word;

  assign w_accept    = rx_valid & rx_ready;
  assign w_len_full  = {rx_data, r_len[7:0]};
  // Fourth byte of the final word is being offered.
  assign w_last_word = (r_byte_idx == 2'd3) && (r_word_idx == (r_len - 16'd1));

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_state_next = r_state;
    rx_ready     = 1'b0;
    cpu_rst      = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) w_state_next = StLen;
      end
      StLen: begin
        rx_ready = 1'b1;
        if (w_accept && (r_byte_idx == 2'd1)) begin
          if (w_len_full > LP_DEPTH)       w_state_next = StErr;
          else if (w_len_full == 16'd0)    w_state_next = StChk;
          else                             w_state_next = StData;
        end
      end
      StData: begin
        rx_ready = 1'b1;
        if (w_accept && w_last_word) w_state_next = StChk;
      end
      StChk: begin
        rx_ready = 1'b1;
        if (w_accept) w_state_next = (rx_data == r_chk) ? StDone : StErr;
      end
      StDone: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
        if (start) w_state_next = StLen;
      end
      StErr: begin
        err = 1'b1;
        if (start) w_state_next = StLen;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Counters, checksum, word assembly and the registered memory write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_len      <= 16'd0;
      r_word_idx <= 16'd0;
      r_byte_idx <= 2'd0;
      r_chk      <= 8'd0;
      r_word     <= 24'd0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        StIdle, StDone, StErr: begin
          if (start) begin
            r_len      <= 16'd0;
            r_word_idx <= 16'd0;
            r_byte_idx <= 2'd0;
            r_chk      <= 8'd0;
          end
        end
        StLen: begin
          if (w_accept) begin
            r_chk <= r_chk ^ rx_data;
            if (r_byte_idx == 2'd0) begin
              r_len[7:0] <= rx_data;
              r_byte_idx <= 2'd1;
            end else begin
              r_len      <= w_len_full;
              r_byte_idx <= 2'd0;
            end
          end
        end
        StData: begin
          if (w_accept) begin
            r_chk      <= r_chk ^ rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_word[7:0]   <= rx_data;
              2'd1: r_word[15:8]  <= rx_data;
              2'd2: r_word[23:16] <= rx_data;
              default: begin
                r_we       <= 1'b1;
                r_addr     <= {14'd0, r_word_idx, 2'b00};
                r_wdata    <= {rx_data, r_word};
                r_word_idx <= r_word_idx + 16'd1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and randomized sessions
// compared against a stream-level reference model.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [63:0] wr_q[$];
  logic [7:0]  stream_q[$];

  prog_loader #(.DEPTH_WORDS(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Capture every cycle that imem_we is high; a stretched strobe shows up as extra entries.
  always @(negedge clk) begin
    if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit rand_start);
    int gap;
    int tmo;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      if (rand_start) start = 1'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    if (rand_start) start = 1'($urandom);
    tmo = 0;
    while (rx_ready !== 1'b1 && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 20) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic begin_session(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_len_ready"}, 32'(rx_ready), 32'd1);
    check({tag, "_len_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, "_len_done"}, 32'(done), 32'd0);
  endtask

  // Fills stream_q with a length-prefixed stream of n random words plus checksum.
  task automatic make_stream(input int n, input bit corrupt);
    logic [7:0] xs;
    logic [7:0] b;
    stream_q.delete();
    stream_q.push_back(8'(n));
    stream_q.push_back(8'(n >> 8));
    xs = 8'(n) ^ 8'(n >> 8);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      stream_q.push_back(b);
      xs ^= b;
    end
    stream_q.push_back(xs ^ {7'd0, corrupt});
  endtask

  // Sends stream_q and compares writes/result with the stream-level model.
  task automatic run_session(input string tag, input int max_gap, input bit rand_start);
    int          n;
    bit          ovf;
    bit          exp_done;
    logic [7:0]  xs;
    logic [63:0] exp_q[$];
    n   = int'({stream_q[1], stream_q[0]});
    ovf = (n > 64);
    xs  = 8'd0;
    exp_done = 1'b0;
    if (!ovf) begin
      for (int i = 0; i < stream_q.size() - 1; i++) xs ^= stream_q[i];
      exp_done = (stream_q[stream_q.size() - 1] == xs);
      for (int w = 0; w < n; w++)
        exp_q.push_back({32'(4 * w), stream_q[5 + 4 * w], stream_q[4 + 4 * w],
                         stream_q[3 + 4 * w], stream_q[2 + 4 * w]});
    end
    wr_q.delete();
    begin_session(tag);
    foreach (stream_q[i]) send_byte(stream_q[i], max_gap, rand_start);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_err"}, 32'(err), 32'(!exp_done));
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
    check({tag, "_ready_after"}, 32'(rx_ready), 32'd0);
    check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      check({tag, "_addr"}, wr_q[i][63:32], exp_q[i][63:32]);
      check({tag, "_data"}, wr_q[i][31:0], exp_q[i][31:0]);
    end
  endtask

  task automatic load_directed();
    stream_q.delete();
    stream_q = '{8'h02, 8'h00, 8'h01, 8'h00, 8'hA0, 8'hE3,
                 8'h02, 8'h10, 8'hA0, 8'hE3, 8'h11};
  endtask

  task automatic check_directed(input string tag);
    check({tag, "_w0"}, (wr_q.size() > 0) ? wr_q[0][31:0] : 32'hX, 32'hE3A00001);
    check({tag, "_a0"}, (wr_q.size() > 0) ? wr_q[0][63:32] : 32'hX, 32'h0);
    check({tag, "_w1"}, (wr_q.size() > 1) ? wr_q[1][31:0] : 32'hX, 32'hE3A01002);
    check({tag, "_a1"}, (wr_q.size() > 1) ? wr_q[1][63:32] : 32'hX, 32'h4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, imem_addr, 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Bytes offered in IDLE are ignored.
    wr_q.delete();
    repeat (5) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    check("idle_ready", 32'(rx_ready), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    rx_valid = 1'b0;
    @(negedge clk);
    check("idle_nwrites", 32'(wr_q.size()), 32'd0);

    load_directed();
    run_session("dir", 0, 1'b0);
    check_directed("dir");

    load_directed();
    run_session("dir_gap", 5, 1'b1);
    check_directed("dir_gap");

    stream_q.delete();
    stream_q = '{8'h00, 8'h00, 8'h00};
    run_session("zero", 0, 1'b0);

    load_directed();
    stream_q[stream_q.size() - 1] = 8'h10;
    run_session("badchk", 2, 1'b0);

    stream_q.delete();
    stream_q = '{8'h41, 8'h00};
    run_session("ovf", 0, 1'b0);
    repeat (3) @(negedge clk);
    check("ovf_ready_later", 32'(rx_ready), 32'd0);

    make_stream(64, 1'b0);
    run_session("full", 0, 1'b0);
    check("full_last_addr", (wr_q.size() == 64) ? wr_q[63][63:32] : 32'hX, 32'hFC);

    for (int k = 0; k < 6; k++) begin
      make_stream(int'($urandom_range(8, 1)), (k % 3) == 2);
      run_session("rand", 5, 1'b1);
    end

    // Reset mid-word: no stray write, then a clean session succeeds.
    stream_q.delete();
    begin_session("midrst");
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    wr_q.delete();
    @(negedge clk);
    rst = 1'b0; rx_valid = 1'b1; rx_data = 8'hA0; start = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b1; rx_valid = 1'b0; start = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_nwrites", 32'(wr_q.size()), 32'd0);
    load_directed();
    run_session("after_rst", 3, 1'b0);
    check_directed("after_rst");

    // Restart from DONE reasserts the processor reset immediately.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_ready", 32'(rx_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
